// File: rtl/ht_ltf_pkg.sv
// Shared types and helpers for the HT-LTF playout buffer: FSM states, IQ sample
// layout, symbol-count mapping and saturating half-negate.
package ht_ltf_pkg;

  localparam int NSAMP    = 80;
  localparam int MAX_NLTF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    READY   = 2'd2,
    PLAY    = 2'd3
  } state_t;

  typedef struct packed {
    logic signed [15:0] i;
    logic signed [15:0] q;
  } iq_t;

  // Index of the last symbol for a requested n_ltf (1, 2 or 4 symbols).
  function automatic logic [1:0] nltf_last_sym(input logic [2:0] n);
    logic [1:0] r;
    case (n)
      3'd0, 3'd1: r = 2'd0;
      3'd2:       r = 2'd1;
      default:    r = 2'd3;
    endcase
    return r;
  endfunction

  // -x for a 16-bit two's complement half, with -32768 clamped to +32767.
  function automatic logic [15:0] neg_sat16(input logic [15:0] x);
    logic [15:0] r;
    if (x == 16'h8000) begin
      r = 16'h7fff;
    end else begin
      r = 16'h0000 - x;
    end
    return r;
  endfunction

endpackage

// File: rtl/iq_neg_sat.sv
// Combinational saturating negate of one IQ sample, applied to both halves when
// neg is set and passing the sample through otherwise.
module iq_neg_sat
  import ht_ltf_pkg::*;
(
  input  logic [31:0] din,
  input  logic        neg,
  output logic [31:0] dout
);

  iq_t s_in_s;
  iq_t s_out_s;

  // Per-half negate, passthrough when polarity is positive.
  always_comb begin
    s_in_s = din;
    if (neg) begin
      s_out_s.i = neg_sat16(s_in_s.i);
      s_out_s.q = neg_sat16(s_in_s.q);
    end else begin
      s_out_s = s_in_s;
    end
  end

  assign dout = s_out_s;

endmodule

// File: rtl/ht_ltf_playout_buffer.sv
// Captures one 80-sample HT-LTF burst and replays it 1/2/4 times on an AXI-stream
// master with per-symbol polarity; the burst stays valid for later replays.
module ht_ltf_playout_buffer #(
  parameter int WIDTH    = 32,
  parameter int NSAMP    = 80,
  parameter int MAX_NLTF = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                ltf_start,
  input  logic [WIDTH-1:0]    ltf_sample,
  input  logic                play,
  input  logic [2:0]          n_ltf,
  input  logic [MAX_NLTF-1:0] p_row,
  output logic [WIDTH-1:0]    o_tdata,
  output logic                o_tvalid,
  input  logic                o_tready,
  output logic                o_tlast,
  output logic                capture_done,
  output logic                busy,
  output logic                err_drop
);
  import ht_ltf_pkg::*;

  localparam logic [6:0] LAST_ADDR = 7'(NSAMP - 1);

  state_t              state_r, state_nxt_s;
  logic [WIDTH-1:0]    mem_r [0:NSAMP-1];
  logic [WIDTH-1:0]    rd_q_r, neg_out_s;
  logic [6:0]          wr_addr_r, wr_addr_s, rd_addr_r, rd_addr_nxt_s;
  logic [1:0]          sym_r, sym_nxt_s, last_sym_r;
  logic [MAX_NLTF-1:0] prow_r, eff_prow_s;
  logic                pending_r;
  logic                wr_en_s, start_s, adv_s, fin_s, drop_s, latch_s, pend_set_s;
  logic                pol_s, xfer_s, rd_last_s;

  assign xfer_s     = o_tvalid & o_tready;
  // rd_q_r holds the beat that will be presented next; these describe that beat.
  assign rd_last_s  = (rd_addr_r == LAST_ADDR) && (sym_r == last_sym_r);
  assign adv_s      = start_s | ((state_r == PLAY) & xfer_s & ~o_tlast);
  assign eff_prow_s = (start_s && play) ? p_row : prow_r;
  assign pol_s      = eff_prow_s[sym_r];

  // Next-state, write control and drop detection.
  always_comb begin
    state_nxt_s = state_r;
    wr_en_s     = 1'b0;
    wr_addr_s   = wr_addr_r;
    start_s     = 1'b0;
    fin_s       = 1'b0;
    drop_s      = 1'b0;
    latch_s     = 1'b0;
    pend_set_s  = 1'b0;
    case (state_r)
      IDLE: begin
        drop_s = play;
        if (ltf_start) begin
          state_nxt_s = CAPTURE;
          wr_en_s     = 1'b1;
          wr_addr_s   = 7'd0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CAPTURE: begin
        wr_en_s    = 1'b1;
        drop_s     = ltf_start;
        latch_s    = play;
        pend_set_s = play;
        if (wr_addr_r == LAST_ADDR) begin
          state_nxt_s = READY;
        end else begin
          state_nxt_s = CAPTURE;
        end
      end
      READY: begin
        if (play || pending_r) begin
          state_nxt_s = PLAY;
          start_s     = 1'b1;
          latch_s     = play;
          drop_s      = ltf_start;
        end else if (ltf_start) begin
          state_nxt_s = CAPTURE;
          wr_en_s     = 1'b1;
          wr_addr_s   = 7'd0;
        end else begin
          state_nxt_s = READY;
        end
      end
      PLAY: begin
        drop_s = ltf_start | play;
        if (xfer_s && o_tlast) begin
          fin_s       = 1'b1;
          state_nxt_s = READY;
        end else begin
          state_nxt_s = PLAY;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Read-ahead address: parked at sample 0 outside PLAY so the first beat is ready.
  always_comb begin
    if (adv_s) begin
      if (rd_addr_r == LAST_ADDR) begin
        rd_addr_nxt_s = 7'd0;
        sym_nxt_s     = sym_r + 2'd1;
      end else begin
        rd_addr_nxt_s = rd_addr_r + 7'd1;
        sym_nxt_s     = sym_r;
      end
    end else if ((state_r == PLAY) && !fin_s) begin
      rd_addr_nxt_s = rd_addr_r;
      sym_nxt_s     = sym_r;
    end else begin
      rd_addr_nxt_s = 7'd0;
      sym_nxt_s     = 2'd0;
    end
  end

  iq_neg_sat u_neg (
    .din  (rd_q_r),
    .neg  (pol_s),
    .dout (neg_out_s)
  );

  // Burst storage write port; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_addr_s] <= ltf_sample;
    end
  end

  // Control state, read-ahead register and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= IDLE;
      wr_addr_r    <= 7'd0;
      rd_addr_r    <= 7'd0;
      sym_r        <= 2'd0;
      last_sym_r   <= 2'd0;
      prow_r       <= '0;
      pending_r    <= 1'b0;
      rd_q_r       <= '0;
      o_tdata      <= '0;
      o_tvalid     <= 1'b0;
      o_tlast      <= 1'b0;
      capture_done <= 1'b0;
      busy         <= 1'b0;
      err_drop     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      rd_addr_r <= rd_addr_nxt_s;
      sym_r     <= sym_nxt_s;
      rd_q_r    <= mem_r[rd_addr_nxt_s];
      if (wr_en_s) begin
        wr_addr_r <= wr_addr_s + 7'd1;
      end
      if (pend_set_s) begin
        pending_r <= 1'b1;
      end else if (start_s) begin
        pending_r <= 1'b0;
      end
      if (latch_s) begin
        prow_r     <= p_row;
        last_sym_r <= nltf_last_sym(n_ltf);
      end
      if (adv_s) begin
        o_tdata  <= neg_out_s;
        o_tvalid <= 1'b1;
        o_tlast  <= rd_last_s;
      end else if (fin_s) begin
        o_tvalid <= 1'b0;
        o_tlast  <= 1'b0;
      end
      capture_done <= (state_nxt_s == READY) || (state_nxt_s == PLAY);
      busy         <= (state_nxt_s == CAPTURE) || (state_nxt_s == PLAY);
      err_drop     <= drop_s;
    end
  end

endmodule

// File: tb/tb_ht_ltf_playout_buffer.sv
// Directed bench for ht_ltf_playout_buffer: a burst-level model predicts every
// output beat, and a per-cycle monitor compares transfers and AXI stability.
module tb_ht_ltf_playout_buffer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ltf_start;
  logic [31:0] ltf_sample;
  logic        play;
  logic [2:0]  n_ltf;
  logic [3:0]  p_row;
  logic [31:0] o_tdata;
  logic        o_tvalid;
  logic        o_tready;
  logic        o_tlast;
  logic        capture_done;
  logic        busy;
  logic        err_drop;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] obs_q[$];
  logic [31:0] buf_m [80];
  beat_t       mon_b;
  int checks = 0;
  int errors = 0;
  int err_cnt = 0;
  int cyc = 0;
  int cd_rise = 0;
  int v_rise = 0;
  int e0;
  logic stall_en = 1'b0;
  logic hold_v = 1'b0, after_last = 1'b0, hold_l = 1'b0, cd_prev = 1'b0, v_prev = 1'b0;
  logic [31:0] hold_d = 32'd0;

  ht_ltf_playout_buffer dut (
    .clk(clk), .rstn(rstn), .ltf_start(ltf_start), .ltf_sample(ltf_sample),
    .play(play), .n_ltf(n_ltf), .p_row(p_row), .o_tdata(o_tdata),
    .o_tvalid(o_tvalid), .o_tready(o_tready), .o_tlast(o_tlast),
    .capture_done(capture_done), .busy(busy), .err_drop(err_drop)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    o_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      o_tready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=still running required=finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] m_neg(input logic [15:0] x);
    int v;
    v = -int'($signed(x));
    if (v > 32767) v = 32767;
    return v[15:0];
  endfunction

  function automatic logic [31:0] m_iq_neg(input logic [31:0] s);
    return {m_neg(s[31:16]), m_neg(s[15:0])};
  endfunction

  function automatic int m_nsym(input int n);
    if (n <= 1) return 1;
    else if (n == 2) return 2;
    else return 4;
  endfunction

  // kind 0: ramp I=n, Q=-n; kind 1: ramp with full-scale corner samples at 3 and 4.
  function automatic logic [31:0] gen(input int kind, input int n);
    logic [31:0] r;
    r = {16'(n), 16'(-n)};
    if (kind == 1 && n == 3) r = 32'h8000_7fff;
    if (kind == 1 && n == 4) r = 32'h7fff_8000;
    return r;
  endfunction

  task automatic enqueue(input int n, input logic [3:0] prow);
    beat_t b;
    for (int k = 0; k < m_nsym(n); k++) begin
      for (int s = 0; s < 80; s++) begin
        b.data = prow[k] ? m_iq_neg(buf_m[s]) : buf_m[s];
        b.last = (k == m_nsym(n) - 1) && (s == 79);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input int kind, input int play_at, input int pn, input logic [3:0] pp);
    for (int i = 0; i < 80; i++) begin
      ltf_start  = (i == 0);
      ltf_sample = gen(kind, i);
      buf_m[i]   = ltf_sample;
      play       = (i == play_at);
      if (i == play_at) begin
        n_ltf = 3'(pn);
        p_row = pp;
      end
      if (i == 40) chk("busy_capture", 32'(busy), 32'd1);
      if (i == 79) chk("capture_done_early", 32'(capture_done), 32'd0);
      tick();
    end
    ltf_start = 1'b0;
    play      = 1'b0;
    chk("capture_done_rise", 32'(capture_done), 32'd1);
    if (play_at >= 0) enqueue(pn, pp);
  endtask

  task automatic do_play(input int pn, input logic [3:0] pp);
    obs_q.delete();
    play  = 1'b1;
    n_ltf = 3'(pn);
    p_row = pp;
    enqueue(pn, pp);
    tick();
    play = 1'b0;
    chk("play_latency", 32'(o_tvalid), 32'd1);
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      if (exp_q.size() == 0 && !o_tvalid && !busy) done = 1'b1;
      else tick();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_%s actual=%0d beats outstanding required=0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) tick();
  endtask

  task automatic wait_beats(input int n);
    bit got = 1'b0;
    for (int i = 0; i < 600 && !got; i++) begin
      if (obs_q.size() >= n) got = 1'b1;
      else tick();
    end
    chk("reach_beat", 32'(got), 32'd1);
  endtask

  // Per-cycle monitor: scoreboard compare on transfers, stall stability, post-last idle.
  always @(negedge clk) begin
    if (!rstn) begin
      hold_v = 1'b0; after_last = 1'b0; cd_prev = 1'b0; v_prev = 1'b0;
    end else begin
      if (after_last) begin
        chk("valid_after_last", 32'(o_tvalid), 32'd0);
        chk("busy_after_last", 32'(busy), 32'd0);
      end
      if (hold_v) begin
        chk("stall_valid", 32'(o_tvalid), 32'd1);
        chk("stall_data", o_tdata, hold_d);
        chk("stall_last", 32'(o_tlast), 32'(hold_l));
      end
      after_last = 1'b0;
      hold_v     = 1'b0;
      if (o_tvalid && o_tready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat actual=%h required=no beat", o_tdata);
        end else begin
          mon_b = exp_q.pop_front();
          chk("beat_data", o_tdata, mon_b.data);
          chk("beat_last", 32'(o_tlast), 32'(mon_b.last));
        end
        obs_q.push_back(o_tdata);
        if (o_tlast) after_last = 1'b1;
      end else if (o_tvalid) begin
        hold_v = 1'b1; hold_d = o_tdata; hold_l = o_tlast;
      end
      if (err_drop) err_cnt++;
      if (capture_done && !cd_prev) cd_rise = cyc;
      if (o_tvalid && !v_prev) v_rise = cyc;
      cd_prev = capture_done;
      v_prev  = o_tvalid;
    end
  end

  initial begin
    rstn = 1'b0; ltf_start = 1'b0; ltf_sample = 32'd0; play = 1'b0; n_ltf = 3'd0; p_row = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 32'(o_tvalid), 32'd0);
    chk("rst_tlast", 32'(o_tlast), 32'd0);
    chk("rst_tdata", o_tdata, 32'd0);
    chk("rst_capture_done", 32'(capture_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err_drop", 32'(err_drop), 32'd0);
    rstn = 1'b1;
    repeat (2) tick();

    // Ramp capture, single plain symbol.
    capture(0, -1, 0, 4'd0);
    do_play(1, 4'b0000);
    drain("ramp");
    chk("ramp_count", 32'(obs_q.size()), 32'd80);
    chk("ramp_beat0", obs_q[0], 32'h0000_0000);
    chk("ramp_beat5", obs_q[5], 32'h0005_fffb);
    chk("ramp_beat79", obs_q[79], 32'h004f_ffb1);
    chk("ramp_ready_done", 32'(capture_done), 32'd1);
    chk("ramp_ready_busy", 32'(busy), 32'd0);

    // Four symbols, symbol 1 negated, with saturation corners.
    capture(1, -1, 0, 4'd0);
    do_play(4, 4'b0010);
    drain("polarity");
    chk("pol_count", 32'(obs_q.size()), 32'd320);
    chk("pol_beat3", obs_q[3], 32'h8000_7fff);
    chk("pol_beat83", obs_q[83], 32'h7fff_8001);
    chk("pol_beat84", obs_q[84], 32'h8001_7fff);
    chk("pol_beat85", obs_q[85], 32'hfffb_0005);
    chk("pol_beat165", obs_q[165], 32'h0005_fffb);

    // Replay of the kept buffer under 50% backpressure.
    stall_en = 1'b1;
    do_play(7, 4'b1001);
    drain("stall");
    stall_en = 1'b0;
    chk("stall_count", 32'(obs_q.size()), 32'd320);
    chk("stall_beat3", obs_q[3], 32'h7fff_8001);

    // Play issued 10 cycles into capture.
    e0 = err_cnt;
    obs_q.delete();
    capture(0, 10, 2, 4'b0011);
    drain("early");
    chk("early_no_err", 32'(err_cnt), 32'(e0));
    chk("early_valid_delay", 32'(v_rise - cd_rise), 32'd1);
    chk("early_count", 32'(obs_q.size()), 32'd160);
    chk("early_beat85", obs_q[85], 32'hfffb_0005);

    // ltf_start during PLAY is dropped.
    e0 = err_cnt;
    do_play(2, 4'b0000);
    wait_beats(20);
    ltf_start = 1'b1;
    ltf_sample = 32'hdead_beef;
    tick();
    ltf_start = 1'b0;
    drain("drop_play");
    chk("drop_play_err", 32'(err_cnt), 32'(e0 + 1));
    chk("drop_play_count", 32'(obs_q.size()), 32'd160);

    // play and ltf_start together in READY: play wins.
    e0 = err_cnt;
    obs_q.delete();
    ltf_start = 1'b1; ltf_sample = 32'h1234_5678;
    play = 1'b1; n_ltf = 3'd0; p_row = 4'b0001;
    enqueue(0, 4'b0001);
    tick();
    ltf_start = 1'b0; play = 1'b0;
    chk("both_latency", 32'(o_tvalid), 32'd1);
    drain("drop_both");
    chk("drop_both_err", 32'(err_cnt), 32'(e0 + 1));
    chk("drop_both_done", 32'(capture_done), 32'd1);
    chk("drop_both_count", 32'(obs_q.size()), 32'd80);
    chk("drop_both_beat1", obs_q[1], 32'hffff_0001);

    // Asynchronous reset in the middle of a playout.
    do_play(2, 4'b0000);
    wait_beats(40);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_tvalid", 32'(o_tvalid), 32'd0);
    chk("mid_rst_tlast", 32'(o_tlast), 32'd0);
    chk("mid_rst_tdata", o_tdata, 32'd0);
    chk("mid_rst_capture_done", 32'(capture_done), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_err_drop", 32'(err_drop), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    tick();
    chk("post_rst_done", 32'(capture_done), 32'd0);
    e0 = err_cnt;
    play = 1'b1; n_ltf = 3'd1; p_row = 4'd0;
    tick();
    play = 1'b0;
    repeat (4) tick();
    chk("post_rst_play_err", 32'(err_cnt), 32'(e0 + 1));
    chk("post_rst_no_valid", 32'(o_tvalid), 32'd0);

    // Recovery: fresh capture and single-symbol play with n_ltf=0.
    obs_q.delete();
    capture(0, -1, 0, 4'd0);
    do_play(0, 4'b0000);
    drain("recover");
    chk("recover_count", 32'(obs_q.size()), 32'd80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
